// File: rtl/tap_window_pkg.sv
// Shared constants and flat-bus indexing for the tapped sample window.
package tap_window_pkg;

    localparam int TW_DEPTH = 3;
    localparam int TW_W     = 5;
    localparam int TW_OSF   = 8;

    // Bit offset of channel c, tap k inside the flat window bus.
    function automatic int tap_off(input int c, input int k, input int w, input int depth);
        return (c * depth + k) * w;
    endfunction

endpackage

// File: rtl/tap_line.sv
// One channel's DEPTH-deep shift chain; tap 0 holds the newest sample.
module tap_line
    import tap_window_pkg::*;
#(
    parameter int DEPTH = TW_DEPTH,
    parameter int W     = TW_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Shift,
    input  logic               Clear,
    input  logic [W-1:0]       DataIn,
    output logic [DEPTH*W-1:0] Taps
);

    logic [W-1:0] taps_q [DEPTH];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
        end else if (Clear) begin
            for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
        end else if (Shift) begin
            taps_q[0] <= DataIn;
            for (int k = 1; k < DEPTH; k++) taps_q[k] <= taps_q[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        assign Taps[tap_off(0, k, W, DEPTH) +: W] = taps_q[k];
    end

endmodule

// File: rtl/tap_window_register.sv
// Multi-channel decimating tapped delay line with fill tracking and new-window strobe.
module tap_window_register
    import tap_window_pkg::*;
#(
    parameter int CH    = 2,
    parameter int DEPTH = TW_DEPTH,
    parameter int W     = TW_W,
    parameter int OSF   = TW_OSF
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Flush,
    input  logic                         InValid,
    input  logic [CH*W-1:0]              DataIn,
    output logic [CH*DEPTH*W-1:0]        DataOut,
    output logic [$clog2(DEPTH+1)-1:0]   FillCnt,
    output logic                         WindowValid,
    output logic                         NewWindow
);

    localparam int FW = $clog2(DEPTH + 1);
    // OSF=1 still gets a 1-bit counter; it simply never leaves 0.
    localparam int DW = (OSF > 1) ? $clog2(OSF) : 1;

    logic [DW-1:0] dec_cnt_q, dec_cnt_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic          new_window_q, new_window_d;
    logic          accept;

    always_comb begin
        accept       = InValid && !Flush && (dec_cnt_q == '0);
        dec_cnt_d    = dec_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        new_window_d = 1'b0;
        if (Flush) begin
            dec_cnt_d  = '0;
            fill_cnt_d = '0;
        end else if (InValid) begin
            dec_cnt_d = (dec_cnt_q == DW'(OSF - 1)) ? '0 : dec_cnt_q + 1'b1;
            if (accept) begin
                if (fill_cnt_q != FW'(DEPTH)) fill_cnt_d = fill_cnt_q + 1'b1;
                new_window_d = (fill_cnt_q >= FW'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dec_cnt_q    <= '0;
            fill_cnt_q   <= '0;
            new_window_q <= 1'b0;
        end else begin
            dec_cnt_q    <= dec_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            new_window_q <= new_window_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        tap_line #(
            .DEPTH (DEPTH),
            .W     (W)
        ) u_line (
            .Clk    (Clk),
            .Reset  (Reset),
            .Shift  (accept),
            .Clear  (Flush),
            .DataIn (DataIn[c*W +: W]),
            .Taps   (DataOut[tap_off(c, 0, W, DEPTH) +: DEPTH*W])
        );
    end

    assign FillCnt     = fill_cnt_q;
    assign WindowValid = (fill_cnt_q == FW'(DEPTH));
    assign NewWindow   = new_window_q;

endmodule

// File: tb/tb_tap_window_register.sv
// Directed bench: three instances (OSF=1, 8, 2) share stimulus; each test checks the relevant one.
module tb_tap_window_register;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [9:0] data_in;

    logic [29:0] dout_a, dout_b, dout_c;
    logic [1:0]  fill_a, fill_b, fill_c;
    logic        wv_a, wv_b, wv_c;
    logic        nw_a, nw_b, nw_c;

    int n_checks = 0;
    int n_fail   = 0;
    int nw_pulses;

    tap_window_register #(.CH(2), .DEPTH(3), .W(5), .OSF(1)) u_dut_a (
        .Clk(clk), .Reset(rst_n), .Flush(flush), .InValid(in_valid), .DataIn(data_in),
        .DataOut(dout_a), .FillCnt(fill_a), .WindowValid(wv_a), .NewWindow(nw_a));

    tap_window_register #(.CH(2), .DEPTH(3), .W(5), .OSF(8)) u_dut_b (
        .Clk(clk), .Reset(rst_n), .Flush(flush), .InValid(in_valid), .DataIn(data_in),
        .DataOut(dout_b), .FillCnt(fill_b), .WindowValid(wv_b), .NewWindow(nw_b));

    tap_window_register #(.CH(2), .DEPTH(3), .W(5), .OSF(2)) u_dut_c (
        .Clk(clk), .Reset(rst_n), .Flush(flush), .InValid(in_valid), .DataIn(data_in),
        .DataOut(dout_c), .FillCnt(fill_c), .WindowValid(wv_c), .NewWindow(nw_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pack3(input int t0, input int t1, input int t2);
        logic [4:0] a, b, c;
        a = 5'(t0);
        b = 5'(t1);
        c = 5'(t2);
        return {c, b, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
    endtask

    logic [14:0] exp_gap [8];

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        #1;
        check_eq("reset_dout", 32'(dout_a), 32'd0);
        check_eq("reset_fill", 32'(fill_a), 32'd0);
        check_eq("reset_wv",   32'(wv_a),   32'd0);
        check_eq("reset_nw",   32'(nw_a),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, OSF=1
        in_valid = 1'b1;
        data_in = {5'd2, 5'd1}; step();
        data_in = {5'd5, 5'd3}; step();
        check_eq("fill2_nw", 32'(nw_a), 32'd0);
        data_in = {5'd6, 5'd4}; step();
        check_eq("fill3_ch0",  32'(dout_a[14:0]),  32'(pack3(4, 3, 1)));
        check_eq("fill3_ch1",  32'(dout_a[29:15]), 32'(pack3(6, 5, 2)));
        check_eq("fill3_cnt",  32'(fill_a), 32'd3);
        check_eq("fill3_wv",   32'(wv_a),   32'd1);
        check_eq("fill3_nw",   32'(nw_a),   32'd1);
        data_in = {5'd9, 5'd7}; step();
        check_eq("fill4_ch0",  32'(dout_a[14:0]),  32'(pack3(7, 4, 3)));
        check_eq("fill4_ch1",  32'(dout_a[29:15]), 32'(pack3(9, 6, 5)));
        check_eq("fill4_nw",   32'(nw_a),   32'd1);
        do_flush();
        check_eq("flush_fill_a", 32'(fill_a), 32'd0);

        // Decimation, OSF=8: samples 0, 8, 16 accepted
        nw_pulses = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            data_in = {5'(i), 5'(i)};
            step();
            if (nw_b) nw_pulses++;
            if (i == 8) check_eq("dec_mid_fill", 32'(fill_b), 32'd2);
            if (i == 16) check_eq("dec_last_nw", 32'(nw_b), 32'd1);
        end
        check_eq("dec_ch0",    32'(dout_b[14:0]),  32'(pack3(16, 8, 0)));
        check_eq("dec_ch1",    32'(dout_b[29:15]), 32'(pack3(16, 8, 0)));
        check_eq("dec_fill",   32'(fill_b), 32'd3);
        check_eq("dec_wv",     32'(wv_b),   32'd1);
        check_eq("dec_pulses", 32'(nw_pulses), 32'd1);
        check_eq("dec_nw_end", 32'(nw_b),   32'd0);
        do_flush();

        // Gaps, OSF=2: valid on even cycles; accepts land on cycles 0 and 4
        exp_gap[0] = pack3(10, 0, 0);
        exp_gap[1] = pack3(10, 0, 0);
        exp_gap[2] = pack3(10, 0, 0);
        exp_gap[3] = pack3(10, 0, 0);
        exp_gap[4] = pack3(14, 10, 0);
        exp_gap[5] = pack3(14, 10, 0);
        exp_gap[6] = pack3(14, 10, 0);
        exp_gap[7] = pack3(14, 10, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            data_in  = {5'(i + 20), 5'(i + 10)};
            step();
            check_eq($sformatf("gap_ch0_%0d", i), 32'(dout_c[14:0]), 32'(exp_gap[i]));
        end
        check_eq("gap_ch1",  32'(dout_c[29:15]), 32'(pack3(24, 20, 0)));
        check_eq("gap_fill", 32'(fill_c), 32'd2);
        check_eq("gap_wv",   32'(wv_c),   32'd0);
        check_eq("gap_nw",   32'(nw_c),   32'd0);

        // Flush collision on a full window (dut_a accepted 10,12,14,16)
        check_eq("coll_pre_wv",  32'(wv_a), 32'd1);
        check_eq("coll_pre_ch0", 32'(dout_a[14:0]), 32'(pack3(16, 14, 12)));
        in_valid = 1'b1;
        flush    = 1'b1;
        data_in  = {5'd30, 5'd31};
        step();
        flush    = 1'b0;
        check_eq("coll_dout", 32'(dout_a), 32'd0);
        check_eq("coll_fill", 32'(fill_a), 32'd0);
        check_eq("coll_wv",   32'(wv_a),   32'd0);
        check_eq("coll_nw",   32'(nw_a),   32'd0);
        data_in = {5'd3, 5'd11}; step();
        check_eq("coll_next_ch0",  32'(dout_a[14:0]), 32'(pack3(11, 0, 0)));
        check_eq("coll_next_fill", 32'(fill_a), 32'd1);
        check_eq("coll_next_nw",   32'(nw_a),   32'd0);

        // Asynchronous reset mid-window
        data_in = {5'd3, 5'd12}; step();
        check_eq("arst_pre_fill", 32'(fill_a), 32'd2);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_dout", 32'(dout_a), 32'd0);
        check_eq("arst_fill", 32'(fill_a), 32'd0);
        check_eq("arst_wv",   32'(wv_a),   32'd0);
        check_eq("arst_nw",   32'(nw_a),   32'd0);
        check_eq("arst_b_dout", 32'(dout_b), 32'd0);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        data_in  = {5'd4, 5'd13};
        step();
        check_eq("arst_post_ch0", 32'(dout_a[14:0]), 32'(pack3(13, 0, 0)));
        check_eq("arst_post_fill", 32'(fill_a), 32'd1);
        check_eq("arst_post_b_ch0", 32'(dout_b[14:0]), 32'(pack3(13, 0, 0)));
        do_flush();

        // Saturation: 10 accepts, DEPTH=3
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = {5'(i + 1), 5'(i + 1)};
            step();
            check_eq($sformatf("sat_fill_%0d", i), 32'(fill_a), (i >= 2) ? 32'd3 : 32'(i + 1));
            check_eq($sformatf("sat_nw_%0d", i),   32'(nw_a),   (i >= 2) ? 32'd1 : 32'd0);
        end
        check_eq("sat_ch0", 32'(dout_a[14:0]), 32'(pack3(10, 9, 8)));
        in_valid = 1'b0;
        step();
        check_eq("sat_idle_nw", 32'(nw_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_window_register.md
# tap_window_register

Multi-channel, parametrised tapped delay line for the oversampled sample path. Takes one W-bit sample per channel, decimates the input stream by OSF, and shifts the accepted samples into a DEPTH-deep window per channel. The full window is exposed as a flat bus, with fill tracking, a window-valid flag and a new-window strobe. It replaces the single-channel, fixed-mode shift register ahead of the correlation and decision logic.

## Interface
- `CH`, default 2: number of parallel channels sharing one control path.
- `DEPTH`, default 3: taps per channel; must be at least 2.
- `W`, default 5: sample width in bits (matches $clog2(SAMPLES*OSF)+1 for SAMPLES=2, OSF=8).
- `OSF`, default 8: decimation factor. 1 means every valid sample is accepted.
- `Clk`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `Flush`  in  1: synchronous clear of the window and all counters.
- `InValid`  in  1: `DataIn` is valid this cycle.
- `DataIn`  in  CH*W: channel c at `[c*W +: W]`.
- `DataOut`  out  CH*DEPTH*W: channel c, tap k at `[(c*DEPTH+k)*W +: W]`. Tap 0 is the newest sample.
- `FillCnt`  out  $clog2(DEPTH+1): number of accepted samples in the window; saturates at DEPTH.
- `WindowValid`  out  1: high while `FillCnt == DEPTH`.
- `NewWindow`  out  1: one-cycle strobe marking each accept that leaves the window full.

## Operation
- Decimation counter `DecCnt` (0..OSF-1):
  - Advances by one on every cycle with `InValid=1` and `Flush=0`.
  - Wraps from OSF-1 to 0.
- Accept condition: `InValid && !Flush && DecCnt==0`. The first valid sample after reset or flush is always accepted.
- On accept, every channel shifts in parallel:
  - tap0 ← that channel's `DataIn` slice.
  - tap k ← tap k-1, for k = 1..DEPTH-1.
  - The old tap DEPTH-1 is discarded.
- Fill tracking:
  - On accept, `FillCnt` increments, saturating at DEPTH.
  - `WindowValid` is true when `FillCnt == DEPTH`.
  - `NewWindow` is registered: it is 1 for exactly the cycle after an accept whose post-update `FillCnt` equals DEPTH, otherwise 0.
- `InValid=0`: taps, `DecCnt` and `FillCnt` all hold.
- `Flush=1`:
  - Next edge sets all taps, `DecCnt` and `FillCnt` to 0 and `NewWindow` to 0.
  - Overrides `InValid` in the same cycle; no sample is accepted.
- Reset (asynchronous, `Reset=0`): all taps, `DecCnt`, `FillCnt` and `NewWindow` go to 0 immediately. This applies mid-window and mid-decimation; the first valid sample after release is accepted.
- Arithmetic: samples are opaque W-bit values with no sign handling. Counters never overflow (wrap and saturate rules above).

## Timing
- All outputs are registered, except `WindowValid`, which is a compare on registered `FillCnt`.
- Accept at edge N gives the following, all visible after edge N:
  - `DataOut` updated.
  - `FillCnt` updated.
  - `NewWindow` = 1 during cycle N..N+1 when applicable.
- Input-to-tap0 latency: 1 clock. Sample in tap k: k+1 accepts after capture.
- Streaming throughput, `InValid` held high: one accept every OSF cycles. With OSF=1, one accept per cycle, and `NewWindow` stays high continuously once full.
- Reset values: `DataOut` = 0, `FillCnt` = 0, `WindowValid` = 0, `NewWindow` = 0.

## Structure
- Package `tap_window_pkg` holds:
  - the tap-index/flat-offset helper function `tap_off(c,k,W,DEPTH)`;
  - default parameter constants `TW_DEPTH`, `TW_W`, `TW_OSF`.
- Sub-module `tap_line`: one channel's DEPTH×W shift chain with a shared `Shift` enable, asynchronous active-low `Reset` and synchronous `Clear`. Instantiated CH times by a generate loop.
- The top level owns `DecCnt`, `FillCnt`, `NewWindow` and the accept logic.

## Test plan
- **Fill, OSF=1, CH=2, DEPTH=3, W=5:**
  - Stimulus: `InValid=1` with ch0 = 1, 3, 4, 7 and ch1 = 2, 5, 6, 9.
  - After the 3rd edge: ch0 taps = {4, 3, 1}, `FillCnt`=3, `WindowValid`=1, `NewWindow`=1.
  - After the 4th edge: ch0 taps = {7, 4, 3}, ch1 taps = {9, 6, 5}.
- **Decimation, OSF=8:**
  - Stimulus: 24 consecutive valid samples valued 0..23.
  - Accepted samples: 0, 8, 16. After the last accept, taps = {16, 8, 0}; `NewWindow` pulses once.
- **Gaps:**
  - Stimulus: `InValid` toggling 1/0 with OSF=2.
  - `DecCnt` advances only on valid cycles; taps are unchanged on invalid cycles.
- **Flush collision:**
  - Stimulus: `Flush=1` and `InValid=1` on the same edge while the window is full.
  - Taps = 0, `FillCnt`=0, `WindowValid`=0, no `NewWindow`. The next valid sample is accepted into tap0.
- **Asynchronous reset mid-window:**
  - Stimulus: `Reset` low between clock edges with `FillCnt`=2.
  - All outputs are 0 before the next edge. After release, the first valid sample is accepted.
- **Saturation:**
  - Stimulus: 10 accepts with DEPTH=3.
  - `FillCnt` stays at 3; `NewWindow` is high after each accept from the 3rd onward.
